// File: rtl/max7219_ctrl_pkg.sv
// max7219_ctrl_pkg: MAX7219 register addresses, NO_OP frame, FSM states and init frame table.
package max7219_ctrl_pkg;
  localparam logic [3:0] A_NO_OP        = 4'h0;
  localparam logic [3:0] A_DIGIT_0      = 4'h1;
  localparam logic [3:0] A_DIGIT_1      = 4'h2;
  localparam logic [3:0] A_DIGIT_2      = 4'h3;
  localparam logic [3:0] A_DIGIT_3      = 4'h4;
  localparam logic [3:0] A_DIGIT_4      = 4'h5;
  localparam logic [3:0] A_DIGIT_5      = 4'h6;
  localparam logic [3:0] A_DIGIT_6      = 4'h7;
  localparam logic [3:0] A_DIGIT_7      = 4'h8;
  localparam logic [3:0] A_DECODE_MODE  = 4'h9;
  localparam logic [3:0] A_INTENSITY    = 4'hA;
  localparam logic [3:0] A_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] A_SHUTDOWN     = 4'hC;
  localparam logic [3:0] A_DISPLAY_TEST = 4'hF;
  localparam logic [15:0] NO_OP_FRAME = {4'h0, A_NO_OP, 8'h00};
  localparam int INIT_LEN = 5;
  typedef enum logic [2:0] {S_IDLE, S_CLK_LOW, S_CLK_HIGH, S_LATCH, S_DONE} state_t;
  function automatic logic [15:0] init_frame(input logic [2:0] i, input logic [7:0] intensity);
    return i == 3'd0 ? {4'h0, A_DISPLAY_TEST, 8'h00} :
           i == 3'd1 ? {4'h0, A_SCAN_LIMIT, 8'h07} :
           i == 3'd2 ? {4'h0, A_DECODE_MODE, 8'h00} :
           i == 3'd3 ? {4'h0, A_INTENSITY, intensity} :
                       {4'h0, A_SHUTDOWN, 8'h01};
  endfunction
endpackage

// File: rtl/max7219_serializer.sv
// max7219_serializer: shifts a W-bit word MSB first with divided clock, then pulses load.
// Ports: clk, rst (sync, active high); start/frame/nbits load a word when not busy;
// busy during shift+latch; done one cycle after load falls; sclk/din/load drive the chain.
module max7219_serializer
  import max7219_ctrl_pkg::*;
#(
  parameter int W = 64,
  parameter int DIV = 4,
  localparam int BW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  frame,
  input  logic [BW:0]   nbits,
  output logic          busy,
  output logic          done,
  output logic          sclk,
  output logic          din,
  output logic          load
);
  state_t state, nxt;
  logic [BW-1:0] bit_cnt;
  logic [7:0] div_cnt;
  logic [W-1:0] sr;
  logic last_div;
  assign last_div = div_cnt == 8'(DIV - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_CLK_LOW : S_IDLE;
      S_CLK_LOW:      nxt = last_div ? S_CLK_HIGH : S_CLK_LOW;
      S_CLK_HIGH:     nxt = !last_div ? S_CLK_HIGH : ({1'b0, bit_cnt} == nbits - 1'b1) ? S_LATCH : S_CLK_LOW;
      S_LATCH:        nxt = last_div ? S_DONE : S_LATCH;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      sr      <= '0;
    end else begin
      state   <= nxt;
      div_cnt <= (nxt == state && nxt != S_IDLE) ? div_cnt + 8'd1 : 8'd0;
      bit_cnt <= (state == S_CLK_HIGH && nxt == S_CLK_LOW) ? bit_cnt + 1'b1 :
                 (nxt == S_CLK_LOW || nxt == S_CLK_HIGH) ? bit_cnt : '0;
      sr      <= (nxt == S_CLK_LOW && (state == S_IDLE || state == S_DONE)) ? frame :
                 (state == S_CLK_HIGH && nxt == S_CLK_LOW) ? sr << 1 : sr;
    end
  end
  assign busy = state == S_CLK_LOW || state == S_CLK_HIGH || state == S_LATCH;
  assign done = state == S_DONE;
  assign sclk = state == S_CLK_HIGH;
  assign load = state == S_LATCH;
  // din is forced low outside the shift so the idle level is 0
  assign din  = (state == S_CLK_LOW || state == S_CLK_HIGH) & sr[W-1];
endmodule

// File: rtl/max7219_ctrl.sv
// max7219_ctrl: request sequencing and frame assembly for a daisy chain of MAX7219 devices.
// Ports: clk, rst (sync, active high); i_req/i_broadcast/i_matrix_sel/i_addr/i_data write request;
// o_busy, o_done status; o_max7219_clk/din/load serial chain interface.
// Define MAX7219_INIT_SEQ_EN to send the five-frame broadcast init sequence after reset.
module max7219_ctrl
  import max7219_ctrl_pkg::*;
#(
  parameter int G_MATRIX_NB = 4,
  parameter int G_CLK_DIV = 4,
  parameter logic [7:0] G_INTENSITY = 8'h08,
  localparam int SW = G_MATRIX_NB > 1 ? $clog2(G_MATRIX_NB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_broadcast,
  input  logic [SW-1:0] i_matrix_sel,
  input  logic [3:0]    i_addr,
  input  logic [7:0]    i_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_max7219_clk,
  output logic          o_max7219_din,
  output logic          o_max7219_load
);
  localparam int W = 16 * G_MATRIX_NB;
  localparam int NB = $clog2(W) + 1;
  logic ser_busy, ser_done, start;
  logic [W-1:0] user_frame, frame;
  // device 0 occupies the low word so it is shifted last
  always_comb begin
    user_frame = '0;
    for (int k = 0; k < G_MATRIX_NB; k++)
      user_frame[16*k +: 16] = (i_broadcast || i_matrix_sel == SW'(k)) ? {4'h0, i_addr, i_data} : NO_OP_FRAME;
  end
`ifdef MAX7219_INIT_SEQ_EN
  logic init_pend, init_txn, init_start;
  logic [2:0] init_idx;
  assign init_start = init_pend & ~ser_busy;
  // init_pend is 1 out of reset; masking with rst keeps o_busy low while held in reset
  assign o_busy = ser_busy | (init_pend & ~rst);
  assign start  = init_start | (i_req & ~o_busy);
  assign frame  = init_start ? {G_MATRIX_NB{init_frame(init_idx, G_INTENSITY)}} : user_frame;
  assign o_done = ser_done & ~init_txn;
  always_ff @(posedge clk) begin
    if (rst) begin
      init_pend <= 1'b1;
      init_idx  <= '0;
      init_txn  <= 1'b0;
    end else if (init_start) begin
      init_idx  <= init_idx + 3'd1;
      init_pend <= init_idx != 3'(INIT_LEN - 1);
      init_txn  <= 1'b1;
    end else if (start) begin
      init_txn  <= 1'b0;
    end
  end
`else
  logic unused_intensity;
  assign unused_intensity = ^G_INTENSITY;
  assign o_busy = ser_busy;
  assign start  = i_req & ~ser_busy;
  assign frame  = user_frame;
  assign o_done = ser_done;
`endif
  max7219_serializer #(.W(W), .DIV(G_CLK_DIV)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .frame (frame),
    .nbits (NB'(W)),
    .busy  (ser_busy),
    .done  (ser_done),
    .sclk  (o_max7219_clk),
    .din   (o_max7219_din),
    .load  (o_max7219_load)
  );
endmodule

// File: tb/tb_max7219_ctrl.sv
// tb_max7219_ctrl: randomized checks of max7219_ctrl against per-device register models.
module tb_max7219_ctrl;
  localparam int N = 4, DIV = 2, N2 = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req = 0, bc = 0, b_req = 0;
  logic [1:0] sel = 0, b_sel = 0;
  logic [3:0] addr = 0;
  logic [7:0] data = 0;
  logic busy, done, mclk, din, load;
  logic b_busy, b_done, b_mclk, b_din, b_load;
  max7219_ctrl #(.G_MATRIX_NB(N), .G_CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_broadcast(bc), .i_matrix_sel(sel), .i_addr(addr), .i_data(data),
    .o_busy(busy), .o_done(done), .o_max7219_clk(mclk), .o_max7219_din(din), .o_max7219_load(load));
  max7219_ctrl #(.G_MATRIX_NB(N2), .G_CLK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .i_req(b_req), .i_broadcast(1'b0), .i_matrix_sel(b_sel), .i_addr(addr), .i_data(data),
    .o_busy(b_busy), .o_done(b_done), .o_max7219_clk(b_mclk), .o_max7219_din(b_din), .o_max7219_load(b_load));
  int tests = 0, fails = 0;
  logic [7:0] m [N][16];
  logic [7:0] e [N][16];
  logic [16*N-1:0] stream = '0;
  int rises = 0, frame_rises = 0, loads = 0, done_cnt = 0, proto_err = 0, load_len = 0, cur_len = 0;
  int b_rises = 0, b_ones = 0, b_done_cnt = 0, b_loads = 0;
  logic pclk = 0, pload = 0, hold_din = 0, b_pclk = 0, b_pload = 0;
  // chain monitor: each device takes its 16-bit slot of the shifted stream when load rises
  always @(negedge clk) begin
    if (rst) begin
      rises = 0;
      cur_len = 0;
    end else begin
      if (mclk && !pclk) begin
        stream = {stream[16*N-2:0], din};
        rises++;
        hold_din = din;
      end
      if (mclk && din !== hold_din) proto_err++;
      if (mclk && load) proto_err++;
      if (load && !pload) begin
        loads++;
        frame_rises = rises;
        rises = 0;
        for (int k = 0; k < N; k++)
          if (stream[16*k+8 +: 4] != 4'h0) m[k][stream[16*k+8 +: 4]] = stream[16*k +: 8];
      end
      if (load) cur_len++;
      else if (pload) begin
        load_len = cur_len;
        cur_len = 0;
      end
      if (done) done_cnt++;
    end
    pclk = mclk;
    pload = load;
  end
  always @(negedge clk) begin
    if (rst) begin
      b_rises = 0;
      b_ones = 0;
    end else begin
      if (b_mclk && !b_pclk) begin
        b_rises++;
        if (b_din) b_ones++;
      end
      if (b_load && !b_pload) b_loads++;
      if (b_done) b_done_cnt++;
    end
    b_pclk = b_mclk;
    b_pload = b_load;
  end
  function automatic int model_diffs();
    int n = 0;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 16; r++)
        if (m[k][r] !== e[k][r]) n++;
    return n;
  endfunction
  // caller is just past a negedge; returns at the negedge where o_done is seen
  task automatic send(input logic b, input logic [1:0] s, input logic [3:0] a, input logic [7:0] d, output int lat);
    req = 1; bc = b; sel = s; addr = a; data = d;
    @(negedge clk);
    req = 0;
    lat = 1;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < N; k++)
      if ((b || int'(s) == k) && a != 4'h0) e[k][a] = d;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, mclk, din, load, b_busy, b_done, b_mclk, b_din, b_load} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs got=%b want=0", {busy, done, mclk, din, load, b_busy, b_done, b_mclk, b_din, b_load});
    end
    rst = 0;
    @(negedge clk);
    tests++;
`ifdef MAX7219_INIT_SEQ_EN
    if (busy !== 1'b1) begin fails++; $display("FAIL reset_release_busy got=%b want=1", busy); end
`else
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got=%b want=0", busy); end
`endif
  endtask
`ifdef MAX7219_INIT_SEQ_EN
  task automatic test_init;
    int cyc = 0;
    while (busy && cyc < 3000) begin @(negedge clk); cyc++; end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      e[k][4'hF] = 8'h00; e[k][4'hB] = 8'h07; e[k][4'h9] = 8'h00; e[k][4'hA] = 8'h08; e[k][4'hC] = 8'h01;
    end
    tests++;
    if (loads !== 5) begin fails++; $display("FAIL init_loads got=%0d want=5", loads); end
    tests++;
    if (done_cnt !== 0) begin fails++; $display("FAIL init_no_done got=%0d want=0", done_cnt); end
    tests++;
    if (model_diffs() !== 0) begin fails++; $display("FAIL init_regs diffs=%0d want=0", model_diffs()); end
  endtask
`endif
  task automatic test_single;
    int lat, l0 = loads, d0 = done_cnt;
    send(0, 2'd2, 4'h1, 8'hA5, lat);
    @(negedge clk);
    tests++;
    if (lat !== 259) begin fails++; $display("FAIL single_latency got=%0d want=259", lat); end
    tests++;
    if (frame_rises !== 64) begin fails++; $display("FAIL single_clk_edges got=%0d want=64", frame_rises); end
    tests++;
    if (load_len !== 2 || loads - l0 !== 1) begin fails++; $display("FAIL single_load len=%0d pulses=%0d want 2,1", load_len, loads - l0); end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done got=%0d want=1", done_cnt - d0); end
    tests++;
    if (m[2][1] !== 8'hA5 || model_diffs() !== 0) begin fails++; $display("FAIL single_regs dev2=%h want=a5 diffs=%0d", m[2][1], model_diffs()); end
  endtask
  task automatic test_broadcast;
    int lat;
    send(1, 2'd0, 4'hA, 8'h0F, lat);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (m[k][4'hA] !== 8'h0F) begin fails++; $display("FAIL broadcast_dev%0d got=%h want=0f", k, m[k][4'hA]); end
    end
    tests++;
    if (model_diffs() !== 0) begin fails++; $display("FAIL broadcast_regs diffs=%0d want=0", model_diffs()); end
  endtask
  task automatic test_random;
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 8'($urandom), lat);
      @(negedge clk);
      tests++;
      if (lat !== 259 || model_diffs() !== 0) begin fails++; $display("FAIL random_%0d latency=%0d diffs=%0d want 259,0", i, lat, model_diffs()); end
    end
  endtask
  task automatic test_busy_ignore;
    int lat, l0 = loads, d0 = done_cnt;
    req = 1; bc = 0; sel = 1; addr = 4'h3; data = 8'h11;
    @(negedge clk);
    req = 0;
    repeat (30) @(negedge clk);
    req = 1; bc = 1; addr = 4'h3; data = 8'hEE;
    @(negedge clk);
    req = 0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got=%b want=1", busy); end
    lat = 0;
    while (!done && lat < 5000) begin @(negedge clk); lat++; end
    e[1][3] = 8'h11;
    repeat (300) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1 || loads - l0 !== 1) begin fails++; $display("FAIL ignore_count done=%0d loads=%0d want 1,1", done_cnt - d0, loads - l0); end
    tests++;
    if (model_diffs() !== 0) begin fails++; $display("FAIL ignore_regs diffs=%0d want=0", model_diffs()); end
  endtask
  task automatic test_back_to_back;
    int lat1, lat2;
    send(0, 2'd0, 4'h5, 8'h3C, lat1);
    send(0, 2'd3, 4'h6, 8'hC3, lat2);
    @(negedge clk);
    tests++;
    if (lat1 !== 259 || lat2 !== 259) begin fails++; $display("FAIL b2b_latency got=%0d,%0d want=259,259", lat1, lat2); end
    tests++;
    if (model_diffs() !== 0) begin fails++; $display("FAIL b2b_regs diffs=%0d want=0", model_diffs()); end
  endtask
  task automatic test_reset_mid;
    int cyc = 0, lat, l0, d0;
    req = 1; bc = 0; sel = 3; addr = 4'h2; data = 8'h5A;
    @(negedge clk);
    req = 0;
    while (rises < 20 && cyc < 500) begin @(negedge clk); cyc++; end
    rst = 1;
    @(negedge clk);
    tests++;
    if ({busy, done, mclk, din, load} !== 5'b0) begin fails++; $display("FAIL midrst_outputs got=%b want=0", {busy, done, mclk, din, load}); end
    rst = 0;
    l0 = loads; d0 = done_cnt;
    repeat (300) @(negedge clk);
    tests++;
    if (loads !== l0 || done_cnt !== d0 || model_diffs() !== 0) begin
      fails++; $display("FAIL midrst_abandon loads=%0d done=%0d diffs=%0d want 0,0,0", loads - l0, done_cnt - d0, model_diffs());
    end
    send(0, 2'd3, 4'h2, 8'h5A, lat);
    @(negedge clk);
    tests++;
    if (lat !== 259 || m[3][2] !== 8'h5A || model_diffs() !== 0) begin
      fails++; $display("FAIL midrst_recover latency=%0d dev3=%h diffs=%0d want 259,5a,0", lat, m[3][2], model_diffs());
    end
  endtask
  task automatic test_out_of_range;
    int lat = 1, r0 = b_rises, d0 = b_done_cnt, l0 = b_loads;
    addr = 4'h1; data = 8'hFF; b_sel = 2'd3; b_req = 1;
    @(negedge clk);
    b_req = 0;
    while (!b_done && lat < 1000) begin @(negedge clk); lat++; end
    @(negedge clk);
    tests++;
    if (lat !== 98) begin fails++; $display("FAIL oor_latency got=%0d want=98", lat); end
    tests++;
    if (b_rises - r0 !== 48 || b_ones !== 0) begin fails++; $display("FAIL oor_frames edges=%0d ones=%0d want 48,0", b_rises - r0, b_ones); end
    tests++;
    if (b_done_cnt - d0 !== 1 || b_loads - l0 !== 1) begin fails++; $display("FAIL oor_done done=%0d loads=%0d want 1,1", b_done_cnt - d0, b_loads - l0); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 16; r++) begin
        m[k][r] = 8'h00;
        e[k][r] = 8'h00;
      end
    test_reset;
`ifdef MAX7219_INIT_SEQ_EN
    test_init;
`endif
    test_single;
    test_broadcast;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_out_of_range;
    tests++;
    if (proto_err !== 0) begin fails++; $display("FAIL protocol_errors got=%0d want=0", proto_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
